// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel push-button debouncer with lockout, release qualification and auto-repeat
// Each channel: 2-flop synchronizer, IDLE/LOCK/WAIT_REL FSM and a shared-width counter.
module debounce_bank #(
  parameter int CHANNELS       = 4,
  parameter int LOCK_CYCLES    = 10000000,
  parameter int RELEASE_CYCLES = 1000000,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_CYCLES  = 5000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] buttons_n,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] pressed,
  output logic                busy
);

  localparam int MAX_LR  = (LOCK_CYCLES > RELEASE_CYCLES) ? LOCK_CYCLES : RELEASE_CYCLES;
  localparam int MAX_ALL = (MAX_LR > REPEAT_CYCLES) ? MAX_LR : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] sp;
  logic [CHANNELS-1:0] sp_prev;
  logic [CHANNELS-1:0] pulse_d;
  logic [CHANNELS-1:0] pressed_d;

  // Synchronizers reset to "released" so no phantom press appears after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '1;
      sync2   <= '1;
      sp_prev <= '0;
    end else begin
      sync1   <= buttons_n;
      sync2   <= sync1;
      sp_prev <= sp;
    end
  end

  assign sp = ~sync2;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           state;
      state_t           state_n;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_n;
      logic             pulse_n;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= state_n;
          cnt   <= cnt_n;
        end
      end

      always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        case (state)
          IDLE: begin
            if (sp[i] && enable[i]) begin
              state_n = LOCK;
              cnt_n   = '0;
              pulse_n = 1'b1;
            end
          end
          LOCK: begin
            if (cnt == LOCK_LAST) begin
              state_n = WAIT_REL;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          WAIT_REL: begin
            // Any change of the synchronized level restarts qualification.
            if (sp[i] != sp_prev[i]) begin
              cnt_n = '0;
            end else if (!sp[i]) begin
              if (cnt == REL_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end else if (REPEAT_EN != 0) begin
              if (cnt == REP_LAST) begin
                pulse_n = 1'b1;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end
            // Held without repeat: counter simply holds, so it can never wrap.
          end
          default: begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        endcase
      end

      assign pulse_d[i]   = pulse_n;
      assign pressed_d[i] = (state_n != IDLE);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse <= '0;
      pressed     <= '0;
      busy        <= 1'b0;
    end else begin
      press_pulse <= pulse_d;
      pressed     <= pressed_d;
      busy        <= |pressed_d;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank against a behavioural reference model
// Two instances share stimulus: one without auto-repeat, one with.
module tb_debounce_bank;

  localparam int CH   = 4;
  localparam int LOCK = 8;
  localparam int REL  = 4;
  localparam int REP  = 6;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH-1:0] buttons_n;
  logic [CH-1:0] enable;
  logic [CH-1:0] pp0, pr0, pp1, pr1;
  logic          busy0, busy1;

  always #5 clock = ~clock;

  debounce_bank #(
    .CHANNELS(CH), .LOCK_CYCLES(LOCK), .RELEASE_CYCLES(REL),
    .REPEAT_EN(0), .REPEAT_CYCLES(REP)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .buttons_n(buttons_n), .enable(enable),
    .press_pulse(pp0), .pressed(pr0), .busy(busy0)
  );

  debounce_bank #(
    .CHANNELS(CH), .LOCK_CYCLES(LOCK), .RELEASE_CYCLES(REL),
    .REPEAT_EN(1), .REPEAT_CYCLES(REP)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .buttons_n(buttons_n), .enable(enable),
    .press_pulse(pp1), .pressed(pr1), .busy(busy1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a channel is "held down" after an accepted press; lock_left
  // counts remaining lockout cycles, age counts cycles the level has been steady.
  bit          m_down   [2][CH];
  int          lock_left[2][CH];
  int          age      [2][CH];
  bit          m_pulse  [2][CH];
  bit [CH-1:0] lvl_prev;
  bit [CH-1:0] pin_d1, pin_d2;
  int          pulses0  [CH];
  int          pulses1  [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < CH; c++) begin
        m_down[n][c] = 0; lock_left[n][c] = 0; age[n][c] = 0; m_pulse[n][c] = 0;
      end
    lvl_prev = '0;
    pin_d1   = '1;
    pin_d2   = '1;
  endtask

  task automatic model_edge();
    bit [CH-1:0] lvl;
    lvl = ~pin_d2;  // the level the design sees arrives two samples late
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < CH; c++) begin
        m_pulse[n][c] = 0;
        if (!m_down[n][c]) begin
          if (lvl[c] && enable[c]) begin
            m_down[n][c] = 1; lock_left[n][c] = LOCK; m_pulse[n][c] = 1;
          end
        end else if (lock_left[n][c] > 0) begin
          lock_left[n][c]--;
          if (lock_left[n][c] == 0) age[n][c] = 0;
        end else if (lvl[c] != lvl_prev[c]) begin
          age[n][c] = 0;
        end else if (!lvl[c]) begin
          if (age[n][c] + 1 == REL) m_down[n][c] = 0;
          else age[n][c]++;
        end else if (n == 1) begin
          if (age[n][c] + 1 == REP) begin
            m_pulse[n][c] = 1; age[n][c] = 0;
          end else age[n][c]++;
        end
      end
    lvl_prev = lvl;
    pin_d2   = pin_d1;
    pin_d1   = buttons_n;
  endtask

  task automatic cmp_outputs();
    logic [CH-1:0] ep0, er0, ep1, er1;
    for (int c = 0; c < CH; c++) begin
      ep0[c] = m_pulse[0][c]; er0[c] = m_down[0][c];
      ep1[c] = m_pulse[1][c]; er1[c] = m_down[1][c];
    end
    check("pulse_norep",   pp0,   ep0);
    check("pressed_norep", pr0,   er0);
    check("busy_norep",    busy0, |er0);
    check("pulse_rep",     pp1,   ep1);
    check("pressed_rep",   pr1,   er1);
    check("busy_rep",      busy1, |er1);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    cmp_outputs();
    for (int c = 0; c < CH; c++) begin
      if (pp0[c]) pulses0[c]++;
      if (pp1[c]) pulses1[c]++;
    end
  endtask

  task automatic clear_pulses();
    for (int c = 0; c < CH; c++) begin
      pulses0[c] = 0; pulses1[c] = 0;
    end
  endtask

  task automatic latency_check(input string tag, input int ch, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pp0[ch]) begin
        lat = k;
        break;
      end
    end
    check(tag, lat, exp_lat);
  endtask

  initial begin
    reset_n   = 1'b0;
    buttons_n = '1;
    enable    = '1;
    model_reset();
    clear_pulses();
    repeat (3) @(posedge clock);
    #1;
    check("reset_pulse",   pp0 | pp1, 0);
    check("reset_pressed", pr0 | pr1, 0);
    check("reset_busy",    busy0 | busy1, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Single press and re-press on channel 0
    buttons_n[0] = 1'b0;
    latency_check("ch0_latency", 0, 3);
    repeat (20) tick();
    buttons_n[0] = 1'b1;
    repeat (12) tick();
    buttons_n[0] = 1'b0;
    latency_check("ch0_repress", 0, 3);
    repeat (10) tick();
    buttons_n[0] = 1'b1;
    repeat (12) tick();

    // Bounce during lockout and during release on channel 1
    clear_pulses();
    buttons_n[1] = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 6; k++) begin
      buttons_n[1] = ~buttons_n[1];
      tick();
    end
    buttons_n[1] = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 3; k++) begin
      buttons_n[1] = 1'b1; tick(); tick();
      buttons_n[1] = 1'b0; tick(); tick();
    end
    buttons_n[1] = 1'b1;
    repeat (12) tick();
    check("ch1_single_pulse", pulses0[1], 1);

    // Enable gate on channel 2
    clear_pulses();
    enable[2]    = 1'b0;
    buttons_n[2] = 1'b0;
    repeat (20) tick();
    check("ch2_gated", pulses0[2], 0);
    enable[2] = 1'b1;
    latency_check("ch2_enable_latency", 2, 1);
    repeat (2) tick();
    enable[2] = 1'b0;
    repeat (20) tick();
    buttons_n[2] = 1'b1;
    enable       = '1;
    repeat (12) tick();

    // Long hold on channel 3: one pulse without repeat, four repeats with it
    clear_pulses();
    buttons_n[3] = 1'b0;
    repeat (40) tick();
    check("ch3_hold_norep", pulses0[3], 1);
    check("ch3_hold_rep",   pulses1[3], 5);
    buttons_n[3] = 1'b1;
    repeat (14) tick();

    // Simultaneous presses, then asynchronous reset mid-lockout
    buttons_n = 4'b1010;
    tick(); tick(); tick();
    check("simul_pulse", pp0, 4'b0101);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pulse",   pp0 | pp1, 0);
    check("async_rst_pressed", pr0 | pr1, 0);
    check("async_rst_busy",    busy0 | busy1, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    latency_check("reaccept_after_reset", 0, 3);
    check("reaccept_both", pp0, 4'b0101);
    buttons_n = '1;
    repeat (14) tick();

    // Randomized bounce and enable activity
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) buttons_n[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) enable[$urandom_range(0, CH - 1)] ^= 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
